// File: rtl/eceg_pkg.sv
// Shared definitions for the ECEG ciphertext serializer.
package eceg_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StCsum
    } ser_state_e;

    localparam int unsigned DefaultOutw = 8;

    // Beats in one frame: four coordinates of DATAWIDTH/OUTW chunks plus the checksum beat.
    function automatic int unsigned beats_per_frame(input int unsigned datawidth,
                                                    input int unsigned outw);
        return 4 * (datawidth / outw) + 1;
    endfunction

endpackage

// File: rtl/eceg_cipher_serializer_if.sv
// Capture and stream handshakes of the ciphertext serializer.
interface eceg_cipher_serializer_if #(
    parameter int unsigned DATAWIDTH = 16,
    parameter int unsigned OUTW      = 8
);

    logic                 in_valid;
    logic                 in_ready;
    logic [DATAWIDTH-1:0] c1x;
    logic [DATAWIDTH-1:0] c1y;
    logic [DATAWIDTH-1:0] c2x;
    logic [DATAWIDTH-1:0] c2y;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUTW-1:0]      out_data;
    logic                 out_sop;
    logic                 out_last;
    logic                 busy;

    // Producer of ciphertexts and consumer of beats.
    modport master (
        output in_valid, c1x, c1y, c2x, c2y, out_ready,
        input  in_ready, out_valid, out_data, out_sop, out_last, busy
    );

    // The serializer itself.
    modport slave (
        input  in_valid, c1x, c1y, c2x, c2y, out_ready,
        output in_ready, out_valid, out_data, out_sop, out_last, busy
    );

endinterface

// File: rtl/eceg_cipher_serializer.sv
// Captures one ECEG ciphertext and streams it as MSB-first OUTW-bit beats
// (C1x, C1y, C2x, C2y) followed by an XOR checksum beat.
module eceg_cipher_serializer
    import eceg_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 16,
    parameter int unsigned OUTW      = DefaultOutw
) (
    input logic                     clk,
    input logic                     rst_n,
    eceg_cipher_serializer_if.slave bus
);

    localparam int unsigned FrameBeats = beats_per_frame(DATAWIDTH, OUTW);
    localparam int unsigned CntW       = $clog2(FrameBeats);
    localparam int unsigned SregW      = 4 * DATAWIDTH;
    // Counter value of the final data beat; the checksum beat follows it.
    localparam logic [CntW-1:0] LastData = CntW'(FrameBeats - 2);

    if (DATAWIDTH % OUTW != 0) begin : gen_width_check
        $error("DATAWIDTH must be an integer multiple of OUTW");
    end

    ser_state_e       state_q, state_d;
    logic [SregW-1:0] sreg_q, sreg_d;
    logic [OUTW-1:0]  csum_q, csum_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [OUTW-1:0]  top_chunk;

    assign top_chunk = sreg_q[SregW-1 -: OUTW];

    // State, shift register, checksum and beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            csum_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            csum_q  <= csum_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: capture in idle, shift/accumulate per accepted data beat.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        csum_d  = csum_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    sreg_d  = {bus.c1x, bus.c1y, bus.c2x, bus.c2y};
                    csum_d  = '0;
                    cnt_d   = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                // out_valid is always high here, so out_ready alone accepts the beat.
                if (bus.out_ready) begin
                    sreg_d = {sreg_q[SregW-OUTW-1:0], {OUTW{1'b0}}};
                    csum_d = csum_q ^ top_chunk;
                    cnt_d  = cnt_q + CntW'(1);
                    if (cnt_q == LastData) begin
                        state_d = StCsum;
                    end
                end
            end
            StCsum: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded purely from registered state; no input-to-output paths.
    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.busy      = (state_q != StIdle);
        bus.out_valid = (state_q != StIdle);
        bus.out_sop   = (state_q == StSend) && (cnt_q == '0);
        bus.out_last  = (state_q == StCsum);
        bus.out_data  = '0;
        unique case (state_q)
            StSend:  bus.out_data = top_chunk;
            StCsum:  bus.out_data = csum_q;
            default: bus.out_data = '0;
        endcase
    end

endmodule
